// File: rtl/nand_reduce_seq.sv
// Streaming W-bit logic reduction unit: folds a packet of words with a selectable
// gate and presents the per-bit result, a scalar reduction bit, the word count and an error flag.
module nand_reduce_seq #(
    parameter int W         = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_bit,
    output logic [CW-1:0] out_count,
    output logic          out_err
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    state_t        state, next_state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          err;
    logic [1:0]    op_q;
    logic          inv_q;

    logic          accept, first, sat;
    logic [1:0]    cur_op;
    logic          cur_inv;
    logic [W-1:0]  folded;
    logic [CW-1:0] cnt_inc;
    logic          err_inc;

    // Reserved modes 6/7 fall back to NAND.
    function automatic logic [1:0] mode_op(input logic [2:0] m);
        case (m)
            3'd2, 3'd3: mode_op = OP_OR;
            3'd4, 3'd5: mode_op = OP_XOR;
            default:    mode_op = OP_AND;
        endcase
    endfunction

    function automatic logic mode_inv(input logic [2:0] m);
        mode_inv = m[0] | (m[2] & m[1]);
    endfunction

    function automatic logic [W-1:0] fold_word(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            OP_AND:  fold_word = a & b;
            OP_OR:   fold_word = a | b;
            default: fold_word = a ^ b;
        endcase
    endfunction

    function automatic logic reduce_bit(input logic [1:0] op, input logic [W-1:0] v);
        case (op)
            OP_AND:  reduce_bit = &v;
            OP_OR:   reduce_bit = |v;
            default: reduce_bit = ^v;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        case (state)
            IDLE, ACC: begin
                if (in_valid) next_state = in_last ? HOLD : ACC;
            end
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The first word of a packet uses the live mode; later words use the latched one.
    always_comb begin
        accept  = in_valid && in_ready;
        first   = (state == IDLE);
        sat     = (cnt == CW'(MAX_WORDS));
        cur_op  = first ? mode_op(mode)  : op_q;
        cur_inv = first ? mode_inv(mode) : inv_q;
        folded  = first ? in_data : fold_word(cur_op, acc, in_data);
        cnt_inc = sat ? cnt : cnt + CW'(1);
        err_inc = (first ? (mode[2] & mode[1]) : err) | sat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            op_q      <= OP_AND;
            inv_q     <= 1'b0;
            out_data  <= '0;
            out_bit   <= 1'b0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            acc <= folded;
            cnt <= cnt_inc;
            err <= err_inc;
            if (first) begin
                op_q  <= cur_op;
                inv_q <= cur_inv;
            end
            if (in_last) begin
                out_data  <= cur_inv ? ~folded : folded;
                out_bit   <= cur_inv ^ reduce_bit(cur_op, folded);
                out_count <= cnt_inc;
                out_err   <= err_inc;
            end
        end else if (state == HOLD && out_ready) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nand_reduce_seq.sv
// Directed bench for nand_reduce_seq at W=4, MAX_WORDS=4.
module tb_nand_reduce_seq;

    localparam int W  = 4;
    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    mode = 3'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_bit;
    logic [CW-1:0] out_count;
    logic          out_err;

    int errors = 0;
    int checks = 0;

    nand_reduce_seq #(.W(W), .MAX_WORDS(MW)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bit(out_bit), .out_count(out_count), .out_err(out_err)
    );

    always #5 clock = ~clock;

    task automatic send_word(input logic [2:0] m, input logic [W-1:0] d, input logic last);
        mode     = m;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 4'b0000 || out_bit !== 1'b0 || out_count !== 3'd0 || out_err !== 1'b0) begin
            errors++; $display("FAIL rst_outs got=%b/%b/%0d/%b exp=0000/0/0/0", out_data, out_bit, out_count, out_err);
        end
    endtask

    task automatic test_single_nand();
        send_word(3'd1, 4'b1111, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL t1_data got=%b exp=0000", out_data); end
        checks++; if (out_bit !== 1'b0 || out_count !== 3'd1 || out_err !== 1'b0) begin
            errors++; $display("FAIL t1_bit_cnt_err got=%b/%0d/%b exp=0/1/0", out_bit, out_count, out_err);
        end
        // Offered data during HOLD must be ignored and outputs held.
        in_valid = 1'b1; in_data = 4'b0110; in_last = 1'b1; mode = 3'd4;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 4'b0000 ||
                          out_bit !== 1'b0 || out_count !== 3'd1 || out_err !== 1'b0) begin
                errors++; $display("FAIL t1_hold%0d got=%b/%b/%b/%b/%0d/%b exp=1/0/0000/0/1/0",
                                   i, out_valid, in_ready, out_data, out_bit, out_count, out_err);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL t1_release got=%b/%b exp=0/1", out_valid, in_ready);
        end
        checks++; if (out_data !== 4'b0000 || out_count !== 3'd1) begin
            errors++; $display("FAIL t1_keep got=%b/%0d exp=0000/1", out_data, out_count);
        end
    endtask

    task automatic test_nand_and();
        send_word(3'd1, 4'b1111, 1'b0);
        send_word(3'd1, 4'b1011, 1'b0);
        send_word(3'd1, 4'b1110, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b0101 || out_bit !== 1'b1 || out_count !== 3'd3 || out_err !== 1'b0) begin
            errors++; $display("FAIL t2_nand got=%b/%b/%b/%0d/%b exp=1/0101/1/3/0", out_valid, out_data, out_bit, out_count, out_err);
        end
        consume();
        send_word(3'd0, 4'b1111, 1'b0);
        send_word(3'd0, 4'b1011, 1'b0);
        send_word(3'd0, 4'b1110, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b1010 || out_bit !== 1'b0 || out_count !== 3'd3) begin
            errors++; $display("FAIL t2_and got=%b/%b/%b/%0d exp=1/1010/0/3", out_valid, out_data, out_bit, out_count);
        end
        consume();
    endtask

    task automatic test_xor_gap();
        send_word(3'd4, 4'b0001, 1'b0);
        idle_cycle();
        send_word(3'd4, 4'b0011, 1'b0);
        idle_cycle();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL t3_gap got=%b/%b exp=0/1", out_valid, in_ready);
        end
        send_word(3'd4, 4'b0111, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b0101 || out_bit !== 1'b0 || out_count !== 3'd3) begin
            errors++; $display("FAIL t3_xor got=%b/%b/%b/%0d exp=1/0101/0/3", out_valid, out_data, out_bit, out_count);
        end
        consume();
        send_word(3'd4, 4'b0001, 1'b0);
        send_word(3'd2, 4'b0011, 1'b0);
        send_word(3'd2, 4'b0111, 1'b1);
        checks++; if (out_data !== 4'b0101 || out_bit !== 1'b0 || out_count !== 3'd3 || out_err !== 1'b0) begin
            errors++; $display("FAIL t3_modechg got=%b/%b/%0d/%b exp=0101/0/3/0", out_data, out_bit, out_count, out_err);
        end
        consume();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) send_word(3'd3, 4'b0000, 1'b0);
        send_word(3'd3, 4'b0000, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b1111 || out_bit !== 1'b1 || out_count !== 3'd4 || out_err !== 1'b1) begin
            errors++; $display("FAIL t4_ovf got=%b/%b/%b/%0d/%b exp=1/1111/1/4/1", out_valid, out_data, out_bit, out_count, out_err);
        end
        consume();
        send_word(3'd3, 4'b0000, 1'b1);
        checks++; if (out_data !== 4'b1111 || out_count !== 3'd1 || out_err !== 1'b0) begin
            errors++; $display("FAIL t4_next got=%b/%0d/%b exp=1111/1/0", out_data, out_count, out_err);
        end
        consume();
        // Exactly MAX_WORDS words is legal.
        for (int i = 0; i < 3; i++) send_word(3'd2, 4'b0001 << i, 1'b0);
        send_word(3'd2, 4'b0000, 1'b1);
        checks++; if (out_data !== 4'b0111 || out_bit !== 1'b1 || out_count !== 3'd4 || out_err !== 1'b0) begin
            errors++; $display("FAIL t4_full got=%b/%b/%0d/%b exp=0111/1/4/0", out_data, out_bit, out_count, out_err);
        end
        consume();
    endtask

    task automatic test_reserved();
        send_word(3'd7, 4'b1100, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b0011 || out_bit !== 1'b1 || out_count !== 3'd1 || out_err !== 1'b1) begin
            errors++; $display("FAIL t5_rsv got=%b/%b/%b/%0d/%b exp=1/0011/1/1/1", out_valid, out_data, out_bit, out_count, out_err);
        end
        consume();
        send_word(3'd5, 4'b1100, 1'b0);
        send_word(3'd5, 4'b1010, 1'b1);
        checks++; if (out_data !== 4'b1001 || out_bit !== 1'b1 || out_count !== 3'd2 || out_err !== 1'b0) begin
            errors++; $display("FAIL t5_xnor got=%b/%b/%0d/%b exp=1001/1/2/0", out_data, out_bit, out_count, out_err);
        end
        consume();
    endtask

    task automatic test_mid_reset();
        send_word(3'd0, 4'b0000, 1'b0);
        send_word(3'd0, 4'b0001, 1'b0);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 3'd0 || out_data !== 4'b0000) begin
            errors++; $display("FAIL t6_reset got=%b/%b/%0d/%b exp=0/1/0/0000", out_valid, in_ready, out_count, out_data);
        end
        send_word(3'd0, 4'b1010, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b1010 || out_bit !== 1'b0 || out_count !== 3'd1 || out_err !== 1'b0) begin
            errors++; $display("FAIL t6_after got=%b/%b/%b/%0d/%b exp=1/1010/0/1/0", out_valid, out_data, out_bit, out_count, out_err);
        end
        // Reset during HOLD drops the pending result.
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_count !== 3'd0) begin
            errors++; $display("FAIL t6_hold_rst got=%b/%b/%0d exp=0/0000/0", out_valid, out_data, out_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_nand();
        test_nand_and();
        test_xor_gap();
        test_overflow();
        test_reserved();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nand_reduce_seq.md
Name: nand_reduce_seq

Overview:
- Parametrised sequential successor to the two-input NAND gate: a streaming W-bit logic reduction unit.
- Accepts a packet of one or more W-bit words over a valid/ready handshake and folds the words together bitwise with a selectable gate (AND/NAND/OR/NOR/XOR/XNOR).
- Presents the per-bit result, a scalar reduction bit, the word count and an error flag on a second valid/ready handshake.
- Sits between a word source and the datapath as a building block for multi-input gate evaluation and parity/all-ones checks.

Parameters:
W, 8, data width in bits (>=1)
MAX_WORDS, 16, maximum legal words per packet (>=1)
CW, $clog2(MAX_WORDS+1), width of out_count (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  3  gate select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved
in_valid  input  1  in_data/in_last/mode valid
in_ready  output  1  block can accept a word this cycle
in_data  input  W  input word
in_last  input  1  marks final word of packet
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  W  per-bit folded result
out_bit  output  1  scalar reduction over all bits of all words of the packet
out_count  output  CW  words accepted in packet, saturating at MAX_WORDS
out_err  output  1  packet exceeded MAX_WORDS or used reserved mode

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-high, named reset.
- Reset: state=IDLE; acc=0, cnt=0, err=0; out_valid=0, out_data=0, out_bit=0, out_count=0, out_err=0; in_ready=1 in the first cycle after reset.
- Accept rule: a word is accepted on a rising edge where in_valid && in_ready. A result is consumed on a rising edge where out_valid && out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Transitions:
  - IDLE, accept with in_last=0 -> ACC.
  - IDLE, accept with in_last=1 -> HOLD.
  - ACC, accept with in_last=1 -> HOLD. ACC otherwise stays in ACC; idle cycles with in_valid=0 are allowed.
  - HOLD, out_ready=1 -> IDLE. HOLD otherwise stays in HOLD and all out_* signals remain stable.
- Mode is sampled only on the first accepted word of a packet (in IDLE) and latched. mode changes during ACC are ignored.
- Base op by latched mode:
  - AND for modes 0/1; OR for 2/3; XOR for 4/5.
  - Inverting modes are 1, 3 and 5.
  - Reserved modes 6/7 behave as NAND and set err.
- Fold:
  - The first word loads acc=in_data.
  - Each later word does acc = acc OP in_data (bitwise).
- Result, registered on the edge that accepts the last word:
  - out_data = inverting ? ~(acc OP last) : (acc OP last).
  - out_bit = inverting ? ~R(final acc) : R(final acc), where R is the unary &, | or ^ matching the base op.
  - Result latency is exactly 1 cycle: out_valid rises in the cycle after the last-word edge.
- Count:
  - cnt increments per accepted word.
  - Accepting a word when cnt==MAX_WORDS sets err; cnt holds at MAX_WORDS and folding continues.
  - out_count and out_err are registered together with out_data.
- Start of next packet: on return to IDLE, acc, cnt and err are cleared. The out_* signals keep their last values but out_valid=0.
- No bypass: a new packet cannot be accepted in the cycle the result is consumed. The first word of the next packet is accepted no earlier than the cycle after the out_valid && out_ready edge. Sustained throughput is therefore one packet per (words + 1) cycles minimum.
- Reset mid-packet or during HOLD: the partial packet or pending result is discarded, with no output pulse; all registers return to reset values on that edge.
- in_valid is ignored in HOLD, and any data present then is not consumed.

Test Plan:
1. W=4, mode=1 (NAND), single word 4'b1111 with in_last=1 -> one cycle later out_valid=1, out_data=4'b0000, out_bit=0, out_count=1, out_err=0; hold 3 cycles with out_ready=0 -> outputs stable; then out_ready=1 -> IDLE, in_ready=1.
2. W=4, NAND packet 1111, 1011, 1110 (last) -> out_data=4'b0101, out_bit=1, out_count=3. Repeat with mode=0 (AND) -> out_data=4'b1010, out_bit=0.
3. W=4, mode=4 (XOR), packet 0001, 0011, 0111 (last), with an in_valid=0 gap between words -> out_data=4'b0101, out_bit=0, out_count=3. Change mode to 2 mid-packet -> result unchanged.
4. MAX_WORDS=4, mode=3 (NOR), 6 words of 0000 -> out_data=4'b1111, out_bit=1, out_count=4, out_err=1. Next packet of 1 word -> out_err=0.
5. mode=7 with word 4'b1100 (last) -> out_data=4'b0011, out_bit=1, out_err=1.
6. Assert reset for 1 cycle after 2 words of a packet -> next cycle state IDLE, out_valid=0, out_count=0. A new single-word AND packet 1010 -> out_data=1010, out_count=1, with no residue from the aborted packet.
